iq_downconverter: RTL

//  Receive-side counterpart of the NCO->DAC transmit path.
//  - Takes offset-binary ADC samples and the NCO's signed sin/cos outputs.
//  - Mixes the samples to baseband I/Q and integrates-and-dumps over DUMP_LEN samples.
//  - Presents each I/Q pair with a valid/ready handshake to downstream demod logic.

---
 rtl/heai_dsp_pkg.sv | 27 ++
 rtl/iq_mix_acc.sv | 59 +++++
 rtl/iq_downconverter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/heai_dsp_pkg.sv
// Shared widths, midscale, sample/product types and width helpers for the receive DSP path.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package heai_dsp_pkg;

  localparam int ADC_W   = 6;
  localparam int LO_W    = 4;
  localparam int ADC_MID = 1 << (ADC_W - 1);

  // Offset-removed ADC sample and full-precision mixer product at the default widths
  typedef logic signed [ADC_W:0]      sample_t;
  typedef logic signed [ADC_W+LO_W:0] prod_t;

  function automatic int adc_midscale(input int adc_width);
    return 1 << (adc_width - 1);
  endfunction

  function automatic int prod_width(input int adc_width, input int lo_width);
    return adc_width + lo_width + 1;
  endfunction

  // Smallest accumulator that holds DUMP_LEN worst-case products without wrapping
  function automatic int acc_min_width(input int adc_width, input int lo_width, input int dump_len);
    return adc_width + lo_width + $clog2(dump_len) + 1;
  endfunction

endpackage

// File: rtl/iq_mix_acc.sv
// One mixer lane: signed multiply, integrate over a dump, capture the dump result.
// Latency: product one cycle after the sample, result register loads on the dump product.
// Backpressure: none locally; the parent decides via load_i whether a dump is captured.
module iq_mix_acc
  import heai_dsp_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_W,
  parameter int LO_WIDTH  = LO_W,
  parameter int ACC_WIDTH = 18
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        smp_vld_i,
  input  logic signed [ADC_WIDTH:0]   x_i,
  input  logic signed [LO_WIDTH-1:0]  lo_i,
  input  logic                        prod_vld_i,
  input  logic                        dump_i,
  input  logic                        load_i,
  output logic signed [ACC_WIDTH-1:0] res_o
);

  localparam int PW = prod_width(ADC_WIDTH, LO_WIDTH);

  logic signed [PW-1:0]        prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, res_q, res_d, sum;

  assign prod_d = PW'(x_i) * PW'(lo_i);
  assign sum    = acc_q + ACC_WIDTH'(prod_q);

  // Accumulate valid products; the dump product closes the sum and restarts from zero
  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    if (prod_vld_i) begin
      acc_d = dump_i ? '0 : sum;
    end
    if (load_i) begin
      res_d = sum;
    end
  end

  // Product, accumulator and held result registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prod_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else begin
      if (smp_vld_i) begin
        prod_q <= prod_d;
      end
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/iq_downconverter.sv
// Mixes offset-binary ADC samples with NCO cos/sin and integrates-and-dumps I/Q; IQ_DC_BLOCK_EN adds DC removal.
// Latency: out_valid 3 cycles after the clk_en cycle of a dump's last sample (4 with IQ_DC_BLOCK_EN).
// Backpressure: result held while out_valid && !out_ready; a dump landing then is dropped and sets sticky overrun.
module iq_downconverter
  import heai_dsp_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_W,
  parameter int LO_WIDTH  = LO_W,
  parameter int DUMP_LEN  = 64,
  parameter int ACC_WIDTH = 18,
  parameter int DC_SHIFT  = 6
) (
  input  logic                 pll_clock,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [ADC_WIDTH-1:0] adc_in,
  input  logic [LO_WIDTH-1:0]  sin_in,
  input  logic [LO_WIDTH-1:0]  cos_in,
  output logic [ACC_WIDTH-1:0] i_out,
  output logic [ACC_WIDTH-1:0] q_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  localparam int                 CW       = $clog2(DUMP_LEN);
  localparam logic [CW-1:0]      CNT_LAST = CW'(DUMP_LEN - 1);
  localparam logic [ADC_WIDTH:0] MIDSCALE = (ADC_WIDTH+1)'(adc_midscale(ADC_WIDTH));

  // A zero leak shift would make the DC estimate follow every sample and null the signal
  generate
    if (ACC_WIDTH < acc_min_width(ADC_WIDTH, LO_WIDTH, DUMP_LEN) || DUMP_LEN < 2 ||
        (DUMP_LEN & (DUMP_LEN - 1)) != 0 || DC_SHIFT < 1) begin : g_bad_cfg
      $error("iq_downconverter: illegal parameter set");
    end
  endgenerate

  logic signed [ADC_WIDTH:0] x_raw;
  assign x_raw = $signed({1'b0, adc_in}) - $signed(MIDSCALE);

  logic signed [ADC_WIDTH:0] s1_x_d, s1_x_q;
  logic [LO_WIDTH-1:0]       s1_sin_d, s1_cos_d, s1_sin_q, s1_cos_q;
  logic                      s1_vld_d, s1_vld_q;

`ifdef IQ_DC_BLOCK_EN
  localparam int DCW = ADC_WIDTH + 1 + DC_SHIFT;

  logic signed [ADC_WIDTH:0] s0_x_q;
  logic [LO_WIDTH-1:0]       s0_sin_q, s0_cos_q;
  logic                      s0_vld_q;
  logic signed [DCW-1:0]     dc_q, dc_d, x_fx;
  logic signed [DCW:0]       dc_err;

  // dc_q carries DC_SHIFT fractional bits so the leak keeps sub-LSB resolution
  assign x_fx   = {x_raw, {DC_SHIFT{1'b0}}};
  assign dc_err = (DCW+1)'(x_fx) - (DCW+1)'(dc_q);
  assign dc_d   = clk_en ? dc_q + DCW'(dc_err >>> DC_SHIFT) : dc_q;

  // Extra front stage: hold the offset-free sample while the DC estimate leaks toward it
  always_ff @(posedge pll_clock) begin
    if (!rst_n) begin
      s0_vld_q <= 1'b0;
      s0_x_q   <= '0;
      s0_sin_q <= '0;
      s0_cos_q <= '0;
      dc_q     <= '0;
    end else begin
      s0_vld_q <= clk_en;
      dc_q     <= dc_d;
      if (clk_en) begin
        s0_x_q   <= x_raw;
        s0_sin_q <= sin_in;
        s0_cos_q <= cos_in;
      end
    end
  end

  assign s1_x_d   = s0_x_q - $signed(dc_q[DCW-1:DC_SHIFT]);
  assign s1_sin_d = s0_sin_q;
  assign s1_cos_d = s0_cos_q;
  assign s1_vld_d = s0_vld_q;
`else
  assign s1_x_d   = x_raw;
  assign s1_sin_d = sin_in;
  assign s1_cos_d = cos_in;
  assign s1_vld_d = clk_en;
`endif

  // S1: register the signed sample and the aligned LO pair
  always_ff @(posedge pll_clock) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_x_q   <= '0;
      s1_sin_q <= '0;
      s1_cos_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) begin
        s1_x_q   <= s1_x_d;
        s1_sin_q <= s1_sin_d;
        s1_cos_q <= s1_cos_d;
      end
    end
  end

  logic          s2_vld_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dump, blocked, load;
  logic          out_valid_q, out_valid_d, overrun_q, overrun_d;

  assign dump    = s2_vld_q && (cnt_q == CNT_LAST);
  assign blocked = out_valid_q && !out_ready;
  assign load    = dump && !blocked;

  // Sample counter, result-valid handshake and sticky overrun next-state
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (s2_vld_q) begin
      cnt_d = dump ? '0 : cnt_q + CW'(1);
    end
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (dump && blocked) begin
      overrun_d = 1'b1;
    end
  end

  // Product-valid stage, counter and handshake state
  always_ff @(posedge pll_clock) begin
    if (!rst_n) begin
      s2_vld_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s2_vld_q    <= s1_vld_q;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  iq_mix_acc #(
    .ADC_WIDTH (ADC_WIDTH),
    .LO_WIDTH  (LO_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mix_i (
    .clk_i      (pll_clock),
    .rst_ni     (rst_n),
    .smp_vld_i  (s1_vld_q),
    .x_i        (s1_x_q),
    .lo_i       (s1_cos_q),
    .prod_vld_i (s2_vld_q),
    .dump_i     (dump),
    .load_i     (load),
    .res_o      (i_out)
  );

  iq_mix_acc #(
    .ADC_WIDTH (ADC_WIDTH),
    .LO_WIDTH  (LO_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mix_q (
    .clk_i      (pll_clock),
    .rst_ni     (rst_n),
    .smp_vld_i  (s1_vld_q),
    .x_i        (s1_x_q),
    .lo_i       (s1_sin_q),
    .prod_vld_i (s2_vld_q),
    .dump_i     (dump),
    .load_i     (load),
    .res_o      (q_out)
  );

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
